// File: rtl/struct_pckg.sv
// Shared types for the instruction aligner: alignment FSM states and the
// halfword classification used to tell 16-bit from 32-bit instructions.
package struct_pckg;

    typedef enum logic [1:0] {
        StEmpty,
        StHalf,
        StUpper
    } align_state_e;

    // A halfword starts a 32-bit instruction iff its two low bits are both set
    localparam logic [1:0] FullOpcode = 2'b11;

    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != FullOpcode;
    endfunction

endpackage

// File: rtl/instr_aligner.sv
// Re-aligns a 32-bit fetch stream containing mixed 16/32-bit instructions into
// one registered instruction per cycle, buffering a straddling upper halfword.
module instr_aligner
    import struct_pckg::*;
#(
    parameter int unsigned PC_W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     i_if_instr,
    input  logic [PC_W-1:0] i_if_pc,
    input  logic            i_if_valid_instr,
    input  logic            i_flush,
    input  logic            i_dec_ready,
    output logic            o_id_ready,
    output logic            o_incr_pc,
    output logic [31:0]     o_instr,
    output logic [PC_W-1:0] o_instr_pc,
    output logic            o_instr_valid,
    output logic            o_is_compressed
);

    align_state_e    state_q, state_d;
    logic [15:0]     buf_q, buf_d;
    logic [PC_W-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic            valid_q, valid_d;
    logic            comp_q, comp_d;

    logic [15:0]     lo_hw, hi_hw;
    logic [PC_W-1:0] pc_plus2;
    logic            consume;

    assign lo_hw      = i_if_instr[15:0];
    assign hi_hw      = i_if_instr[31:16];
    assign pc_plus2   = i_if_pc + PC_W'(2);
    assign o_id_ready = ~valid_q | i_dec_ready;
    // Gated by rst_n so o_incr_pc reads 1 throughout reset
    assign consume    = rst_n & i_if_valid_instr & o_id_ready & ~i_flush;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_pc_d   = buf_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        comp_d     = comp_q;
        o_incr_pc  = 1'b1;

        if (i_flush) begin
            state_d  = StEmpty;
            buf_d    = '0;
            buf_pc_d = '0;
            valid_d  = 1'b0;
        end else if (consume) begin
            valid_d = 1'b1;
            case (state_q)
                StEmpty: begin
                    instr_pc_d = i_if_pc;
                    if (!is_compressed(lo_hw)) begin
                        instr_d = i_if_instr;
                        comp_d  = 1'b0;
                    end else begin
                        instr_d = {16'h0000, lo_hw};
                        comp_d  = 1'b1;
                        if (is_compressed(hi_hw)) begin
                            state_d   = StUpper;
                            o_incr_pc = 1'b0;
                        end else begin
                            buf_d    = hi_hw;
                            buf_pc_d = pc_plus2;
                            state_d  = StHalf;
                        end
                    end
                end
                StHalf: begin
                    instr_d    = {lo_hw, buf_q};
                    instr_pc_d = buf_pc_q;
                    comp_d     = 1'b0;
                    if (is_compressed(hi_hw)) begin
                        state_d   = StUpper;
                        o_incr_pc = 1'b0;
                    end else begin
                        buf_d    = hi_hw;
                        buf_pc_d = pc_plus2;
                    end
                end
                StUpper: begin
                    instr_d    = {16'h0000, hi_hw};
                    instr_pc_d = pc_plus2;
                    comp_d     = 1'b1;
                    state_d    = StEmpty;
                end
                default: state_d = StEmpty;
            endcase
        end else if (i_dec_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            buf_q      <= '0;
            buf_pc_q   <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            comp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_pc_q   <= buf_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            comp_q     <= comp_d;
        end
    end

    assign o_instr         = instr_q;
    assign o_instr_pc      = instr_pc_q;
    assign o_instr_valid   = valid_q;
    assign o_is_compressed = comp_q;

endmodule

// File: doc/instr_aligner.md
INSTR_ALIGNER -- requirements
Module: instr_aligner

Interface
REQ-001 SHALL have parameter PC_W, default 64, PC width.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_if_instr  input  32  fetched word.
REQ-005 SHALL have port i_if_pc  input  PC_W  address of the fetched word; bits [1:0] always 0.
REQ-006 SHALL have port i_if_valid_instr  input  1  fetched word valid.
REQ-007 SHALL have port i_flush  input  1  branch or jump taken in EX.
REQ-008 SHALL have port i_dec_ready  input  1  decoder accepts o_instr this cycle.
REQ-009 SHALL have port o_id_ready  output  1  to IF; IF advances only when high.
REQ-010 SHALL have port o_incr_pc  output  1  to IF; low makes IF re-present the same word.
REQ-011 SHALL have port o_instr  output  32  aligned instruction; compressed instructions zero-extended in [15:0].
REQ-012 SHALL have port o_instr_pc  output  PC_W  address of o_instr.
REQ-013 SHALL have port o_instr_valid  output  1  o_instr valid.
REQ-014 SHALL have port o_is_compressed  output  1  o_instr is a 16-bit instruction.

Function
REQ-015 SHALL classify a halfword as compressed iff bits [1:0] != 2'b11.
REQ-016 SHALL implement states EMPTY (no buffered halfword), HALF (upper halfword of the previous word buffered, with its PC), and UPPER (the re-presented word's upper compressed halfword is pending).
REQ-017 SHALL consume a word only when i_if_valid_instr=1, o_id_ready=1 and i_flush=0; otherwise state, buffer and outputs SHALL hold.
REQ-018 SHALL drive o_id_ready = ~o_instr_valid | i_dec_ready, combinationally.
REQ-019 In EMPTY, low halfword not compressed: SHALL emit the word at i_if_pc, stay in EMPTY, and drive o_incr_pc=1.
REQ-020 In EMPTY, low halfword compressed, upper halfword compressed: SHALL emit the low halfword at i_if_pc, go to UPPER, and drive o_incr_pc=0.
REQ-021 In EMPTY, low halfword compressed, upper halfword not compressed: SHALL emit the low halfword, buffer the upper halfword with PC i_if_pc+2, go to HALF, and drive o_incr_pc=1.
REQ-022 In HALF: SHALL emit {i_if_instr[15:0], buffer} at the buffered PC; then:
  - upper halfword compressed: go to UPPER with o_incr_pc=0.
  - otherwise: re-buffer the upper halfword at i_if_pc+2, stay in HALF, o_incr_pc=1.
REQ-023 In UPPER: SHALL emit i_if_instr[31:16] at i_if_pc+2, go to EMPTY, and drive o_incr_pc=1.
REQ-024 SHALL compute o_incr_pc combinationally from state and i_if_instr; when no word is consumed it SHALL be 1.
REQ-025 SHALL register outputs with latency 1: an instruction emitted in cycle N is valid on o_instr* in cycle N+1.
REQ-026 SHALL keep o_instr* stable while o_instr_valid=1 and i_dec_ready=0.
REQ-027 SHALL clear o_instr_valid when i_dec_ready=1 and no new instruction is emitted.
REQ-028 On i_flush=1, SHALL in the next cycle enter EMPTY, discard the buffer, and set o_instr_valid=0; flush has priority over every other event.
REQ-029 SHALL compute PC+2 modulo 2^PC_W.

Reset
REQ-030 While rst_n=0, SHALL hold state EMPTY, buffer 0, o_instr=0, o_instr_pc=0, o_instr_valid=0 and o_is_compressed=0; o_id_ready=1 and o_incr_pc=1.
REQ-031 Reset asserted mid-operation SHALL discard the buffered halfword and any pending instruction immediately.

Structure
REQ-032 SHALL place the state enum (EMPTY/HALF/UPPER) and the compressed-halfword classification constant in struct_pckg.
REQ-033 SHALL be a single module with no sub-modules; RVC expansion remains in the decoder.

Verification
REQ-034 Reset release: o_instr_valid=0, o_id_ready=1, o_incr_pc=1, state EMPTY.
REQ-035 Word 0x00000013 at 0x100 -> next cycle o_instr=0x00000013, o_instr_pc=0x100, valid=1, compressed=0; o_incr_pc=1.
REQ-036 Word 0x00010001 at 0x100 -> o_incr_pc=0 in the same cycle; then 0x0001@0x100, then 0x0001@0x102 (compressed=1 both); o_incr_pc=1 in UPPER.
REQ-037 Words 0x00130001@0x100 then 0x00010000@0x104 -> 0x0001@0x100, 0x00000013@0x102, then 0x0001@0x106; o_incr_pc=0 while in HALF with a compressed upper halfword.
REQ-038 i_dec_ready=0 with o_instr_valid=1 -> o_id_ready=0 and o_instr/o_instr_pc unchanged for 3 cycles; resumes in order after i_dec_ready=1.
REQ-039 i_flush=1 while in HALF -> next cycle o_instr_valid=0, state EMPTY, buffered halfword never emitted.
